// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM state encodings and command codes for the sequencer and the command/address encoder.
// Every I_*/W_*/CMD_* value lives here so neither side carries local literals.
package sdram_ctrl_pkg;

    localparam int CNT_W = 15;

    typedef enum logic [4:0] {
        I_NOP  = 5'd0,
        I_PRE,
        I_TRP,
        I_AR1, I_TRF1,
        I_AR2, I_TRF2,
        I_AR3, I_TRF3,
        I_AR4, I_TRF4,
        I_AR5, I_TRF5,
        I_AR6, I_TRF6,
        I_AR7, I_TRF7,
        I_AR8, I_TRF8,
        I_MRS,
        I_TMRD,
        I_DONE = 5'd21
    } init_state_t;

    typedef enum logic [3:0] {
        W_IDLE     = 4'd0,
        W_ACTIVE_R,
        W_ACTIVE_W,
        W_TRCD,
        W_READ,
        W_CL,
        W_RD,
        W_B_R_STOP,
        W_WRITE,
        W_WD,
        W_B_W_STOP,
        W_TDAL,
        W_AR,
        W_TRFC     = 4'd13
    } work_state_t;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_MRS  = 4'b0000,
        CMD_AR   = 4'b0001,
        CMD_PRE  = 4'b0010,
        CMD_ACT  = 4'b0011,
        CMD_WR   = 4'b0100,
        CMD_RD   = 4'b0101,
        CMD_BST  = 4'b0110,
        CMD_NOP  = 4'b0111
    } cmd_t;

endpackage

// File: rtl/sdram_ctrl_ref_timer.sv
// Auto-refresh interval timer: counts while enabled and raises a sticky refresh request on expiry.
// Repeated expiries while a request is outstanding collapse into the same request.
module sdram_ref_timer #(
    parameter int REF_INTERVAL = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic ref_pending
);

    localparam int W = $clog2(REF_INTERVAL);

    logic [W-1:0] cnt;
    logic         expire;

    assign expire = en && (cnt == W'(REF_INTERVAL - 1));

    // NOTE: synchronous reset; every flop, counters included, is cleared on the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            ref_pending <= 1'b0;
        end else begin
            if (en) cnt <= expire ? '0 : cnt + 1'b1;
            // A fresh expiry outranks a clear so a due refresh is never dropped.
            if (expire)   ref_pending <= 1'b1;
            else if (clr) ref_pending <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_ctrl.sv
// SDRAM sequencer: power-up init chain, periodic auto-refresh and full-page 256-word event bursts.
// All handshake outputs are registered from the next-state decode so they align with the state register.
module sdram_ctrl
    import sdram_ctrl_pkg::*;
#(
    parameter int T_POWERUP    = 20000,
    parameter int T_RP         = 3,
    parameter int T_RFC        = 7,
    parameter int T_MRD        = 2,
    parameter int T_RCD        = 3,
    parameter int CAS_LAT      = 3,
    parameter int BURST_LEN    = 256,
    parameter int REF_INTERVAL = 780
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sdram_wr_req,
    input  logic       sdram_rd_req,
    output logic       sdram_wr_ack,
    output logic       sdram_rd_ack,
    output logic       wr_data_en,
    output logic       rd_data_vld,
    output logic       sdram_busy,
    output logic [4:0] init_state,
    output logic [3:0] work_state
);

    init_state_t      init_q, init_d;
    work_state_t      work_q, work_d;
    logic [CNT_W-1:0] cnt, dur;
    logic             cnt_done, wr_dir, ref_pending, ref_clr;

    assign init_state = init_q;
    assign work_state = work_q;

    // NOTE: every variable gets a default first so no path through always_comb infers a latch.
    always_comb begin
        dur = CNT_W'(1);
        if (init_q != I_DONE) begin
            case (init_q)
                I_NOP:   dur = CNT_W'(T_POWERUP);
                I_TRP:   dur = CNT_W'(T_RP);
                I_TRF1, I_TRF2, I_TRF3, I_TRF4,
                I_TRF5, I_TRF6, I_TRF7, I_TRF8:
                         dur = CNT_W'(T_RFC);
                I_TMRD:  dur = CNT_W'(T_MRD);
                default: dur = CNT_W'(1);
            endcase
        end else begin
            case (work_q)
                W_TRCD:  dur = CNT_W'(T_RCD);
                W_CL:    dur = CNT_W'(CAS_LAT);
                W_RD:    dur = CNT_W'(BURST_LEN);
                W_WD:    dur = CNT_W'(BURST_LEN - 1);
                W_TDAL:  dur = CNT_W'(T_RP);
                W_TRFC:  dur = CNT_W'(T_RFC);
                default: dur = CNT_W'(1);
            endcase
        end
        cnt_done = (cnt == dur - CNT_W'(1));
    end

    always_comb begin
        init_d = init_q;
        if (init_q > I_DONE)                 init_d = I_NOP;
        else if (init_q != I_DONE && cnt_done) init_d = init_state_t'(init_q + 5'd1);
    end

    always_comb begin
        work_d = work_q;
        if (init_q != I_DONE) begin
            work_d = W_IDLE;
        end else if (work_q == W_IDLE) begin
            if (ref_pending)       work_d = W_AR;
            else if (sdram_wr_req) work_d = W_ACTIVE_W;
            else if (sdram_rd_req) work_d = W_ACTIVE_R;
        end else if (cnt_done) begin
            case (work_q)
                W_ACTIVE_R, W_ACTIVE_W: work_d = W_TRCD;
                W_TRCD:     work_d = wr_dir ? W_WRITE : W_READ;
                W_READ:     work_d = W_CL;
                W_CL:       work_d = W_RD;
                W_RD:       work_d = W_B_R_STOP;
                W_B_R_STOP: work_d = W_TDAL;
                W_WRITE:    work_d = W_WD;
                W_WD:       work_d = W_B_W_STOP;
                W_B_W_STOP: work_d = W_TDAL;
                W_AR:       work_d = W_TRFC;
                default:    work_d = W_IDLE;
            endcase
        end
    end

    assign ref_clr = (work_q == W_IDLE) && (work_d == W_AR);

    sdram_ref_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_ref_timer (
        .clk        (clk),
        .rst        (rst),
        .en         (init_q == I_DONE),
        .clr        (ref_clr),
        .ref_pending(ref_pending)
    );

    // NOTE: state and outputs use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            init_q       <= I_NOP;
            work_q       <= W_IDLE;
            cnt          <= '0;
            wr_dir       <= 1'b0;
            sdram_wr_ack <= 1'b0;
            sdram_rd_ack <= 1'b0;
            wr_data_en   <= 1'b0;
            rd_data_vld  <= 1'b0;
            sdram_busy   <= 1'b1;
        end else begin
            init_q <= init_d;
            work_q <= work_d;
            cnt    <= (init_d != init_q || work_d != work_q) ? '0 : cnt + 1'b1;
            if (work_d == W_ACTIVE_W)      wr_dir <= 1'b1;
            else if (work_d == W_ACTIVE_R) wr_dir <= 1'b0;
            sdram_wr_ack <= (work_d == W_ACTIVE_W);
            sdram_rd_ack <= (work_d == W_ACTIVE_R);
            wr_data_en   <= (work_d inside {W_WRITE, W_WD});
            rd_data_vld  <= (work_d == W_RD);
            sdram_busy   <= !(init_d == I_DONE && work_d == W_IDLE);
        end
    end

endmodule
